// File: rtl/wb8_sram.sv
// rtl/wb8_sram.sv - Wishbone 8-bit slave queuing byte requests to an async SRAM
module wb8_sram #(
    parameter int ADDR_WIDTH  = 19,
    parameter int WAIT_CYCLES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  CYC_I,
    input  logic                  STB_I,
    input  logic                  WE_I,
    input  logic [31:0]           ADR_I,
    input  logic [7:0]            DAT_I,
    output logic [7:0]            DAT_O,
    output logic                  ACK_O,
    output logic                  STALL_O,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [7:0]            sram_dq_o,
    output logic                  sram_dq_oe,
    input  logic [7:0]            sram_dq_i,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + ADDR_WIDTH + 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, RECOVER} state_t;

    logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;
    logic [EW-1:0]         head;
    logic                  fifo_ne, push, pop;
    state_t                state, state_d;
    logic [3:0]            wait_cnt;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [7:0]            lat_data;
    logic                  last_active;
    logic                  unused_adr;

    assign unused_adr = ^ADR_I[31:ADDR_WIDTH];

    assign STALL_O = (count == (PW+1)'(FIFO_DEPTH));
    assign fifo_ne = (count != '0);
    assign push    = CYC_I & STB_I & ~STALL_O;
    assign head    = fifo_mem[rd_ptr];

    always_ff @(posedge CLK_I) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {WE_I, ADR_I[ADDR_WIDTH-1:0], DAT_I};
        end
    end

    // Dropping CYC_I abandons every queued request.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (!CYC_I) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign last_active = (state == ACTIVE) && (wait_cnt == 4'd0);

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_ne && CYC_I) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP:  state_d = ACTIVE;
            ACTIVE: if (wait_cnt == 4'd0) state_d = RECOVER;
            RECOVER: begin
                if (fifo_ne && CYC_I) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state    <= IDLE;
            wait_cnt <= '0;
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            ACK_O    <= 1'b0;
            DAT_O    <= '0;
        end else begin
            state <= state_d;
            if (pop) begin
                {lat_we, lat_addr, lat_data} <= head;
            end
            if (state == SETUP) begin
                wait_cnt <= 4'(WAIT_CYCLES - 1);
            end else if (state == ACTIVE && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            // An access abandoned by CYC_I completes on the pins but is not acknowledged.
            ACK_O <= last_active && CYC_I;
            if (last_active && CYC_I && !lat_we) begin
                DAT_O <= sram_dq_i;
            end
        end
    end

    // Strobes decode from the state register so reset releases them without a clock.
    assign sram_addr  = lat_addr;
    assign sram_dq_o  = lat_data;
    assign sram_ce_n  = (state == IDLE);
    assign sram_dq_oe = lat_we && (state != IDLE);
    assign sram_oe_n  = !((state == ACTIVE) && !lat_we);
    assign sram_we_n  = !((state == ACTIVE) && lat_we);
endmodule

// File: tb/tb_wb8_sram.sv
// tb/tb_wb8_sram.sv - randomized and directed checks of wb8_sram against a transaction model
`timescale 1ns/1ps
module tb_wb8_sram;
    localparam int AW = 19;
    localparam int WC = 2;
    localparam int FD = 4;

    logic          CLK_I = 1'b0;
    logic          RST_I = 1'b0;
    logic          CYC_I = 1'b0;
    logic          STB_I = 1'b0;
    logic          WE_I  = 1'b0;
    logic [31:0]   ADR_I = '0;
    logic [7:0]    DAT_I = '0;
    logic [7:0]    DAT_O;
    logic          ACK_O;
    logic          STALL_O;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_dq_o;
    logic          sram_dq_oe;
    logic [7:0]    sram_dq_i;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;

    wb8_sram #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC), .FIFO_DEPTH(FD)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
        .ADR_I(ADR_I), .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK_O(ACK_O), .STALL_O(STALL_O),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    always #5 CLK_I = ~CLK_I;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] sram    [0:1023];
    logic [7:0] ref_mem [0:1023];

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr[9:0]] : 8'h00;

    always @(posedge sram_we_n) begin
        if (!sram_ce_n && sram_dq_oe) sram[sram_addr[9:0]] = sram_dq_o;
    end

    always @(posedge CLK_I) cyc++;

    int         ack_cyc [$];
    logic [7:0] ack_dat [$];
    int         oe_low, we_low, dqoe_cnt, proto_err;
    logic       stall_seen;

    always @(negedge CLK_I) begin
        if (ACK_O) begin
            ack_cyc.push_back(cyc);
            ack_dat.push_back(DAT_O);
        end
        if (!sram_oe_n) oe_low++;
        if (!sram_we_n) we_low++;
        if (sram_dq_oe) dqoe_cnt++;
        if (STALL_O) stall_seen = 1'b1;
        if ((!sram_oe_n && !sram_we_n) || (sram_dq_oe && !sram_oe_n)) proto_err++;
    end

    typedef struct {
        logic       we;
        logic [31:0] adr;
        logic [7:0] dat;
        logic [7:0] exp;
    } req_t;
    req_t burst [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        ack_cyc.delete();
        ack_dat.delete();
        oe_low     = 0;
        we_low     = 0;
        dqoe_cnt   = 0;
        stall_seen = 1'b0;
    endtask

    // Model: SRAM effects happen in acceptance order, so reads see all earlier writes.
    task automatic add_req(input logic we, input logic [31:0] adr, input logic [7:0] dat);
        req_t r;
        r.we  = we;
        r.adr = adr;
        r.dat = dat;
        r.exp = ref_mem[adr[9:0]];
        if (we) ref_mem[adr[9:0]] = dat;
        burst.push_back(r);
    endtask

    task automatic drive(input logic we, input logic [31:0] adr, input logic [7:0] dat);
        STB_I = 1'b1;
        WE_I  = we;
        ADR_I = adr;
        DAT_I = dat;
    endtask

    // Accepted requests into an idle block complete every WC+2 cycles from the first edge.
    task automatic check_acks(input int e0, input string tag);
        check({tag, "_ack_count"}, ack_cyc.size(), burst.size());
        for (int k = 0; k < burst.size(); k++) begin
            if (k < ack_cyc.size()) begin
                check({tag, "_ack_cycle"}, ack_cyc[k], e0 + (WC + 2) * (k + 1));
                if (!burst[k].we) check({tag, "_rdata"}, ack_dat[k], burst[k].exp);
            end
        end
    endtask

    task automatic run_burst(input string tag);
        int e0 = 0;
        for (int i = 0; i < burst.size(); i++) begin
            @(negedge CLK_I);
            if (i == 0) e0 = cyc + 1;
            drive(burst[i].we, burst[i].adr, burst[i].dat);
        end
        @(negedge CLK_I);
        STB_I = 1'b0;
        repeat (burst.size() * (WC + 2) + 6) @(negedge CLK_I);
        check_acks(e0, tag);
    endtask

    initial begin
        int e0;
        for (int i = 0; i < 1024; i++) begin
            sram[i]    = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        proto_err = 0;
        clear_mon();
        repeat (3) @(negedge CLK_I);
        check("reset_ctrl", {ACK_O, DAT_O, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, STALL_O},
              {1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        check("reset_addr", sram_addr, 0);
        check("reset_dq_o", sram_dq_o, 0);
        RST_I = 1'b1;
        CYC_I = 1'b1;
        repeat (2) @(negedge CLK_I);

        // Single read latency and oe_n width
        sram[10'h010] = 8'hA5;
        ref_mem[10'h010] = 8'hA5;
        clear_mon();
        burst.delete();
        add_req(1'b0, 32'h10, 8'h00);
        run_burst("t1");
        check("t1_oe_low_cycles", oe_low, WC);

        // Back-to-back reads
        for (int i = 0; i < 4; i++) begin
            sram[10'h100 + i]    = 8'h11 * (i + 1);
            ref_mem[10'h100 + i] = 8'h11 * (i + 1);
        end
        clear_mon();
        burst.delete();
        for (int i = 0; i < 4; i++) add_req(1'b0, 32'h100 + i, 8'h00);
        run_burst("t2");
        check("t2_stall_seen", stall_seen, 1'b0);

        // Back-to-back writes
        clear_mon();
        burst.delete();
        for (int i = 0; i < 4; i++) add_req(1'b1, 32'h200 + i, 8'h44 - 8'h11 * i);
        run_burst("t3");
        for (int i = 0; i < 4; i++) check("t3_sram_byte", sram[10'h200 + i], 8'h44 - 8'h11 * i);
        check("t3_we_low_cycles", we_low, 4 * WC);
        check("t3_dq_oe_cycles", dqoe_cnt, 4 * (WC + 2));

        // One request starts the FSM, five more follow; the last meets a full queue
        clear_mon();
        burst.delete();
        for (int i = 0; i < 5; i++) add_req(1'b0, 32'h300 + i, 8'h00);
        e0 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK_I);
            check("t4_stall", STALL_O, (i == 5));
            if (i == 0) e0 = cyc + 1;
            drive(1'b0, 32'h300 + i, 8'h00);
        end
        @(negedge CLK_I);
        STB_I = 1'b0;
        repeat (6 * (WC + 2) + 6) @(negedge CLK_I);
        check_acks(e0, "t4");

        // Asynchronous reset in the middle of a write strobe
        clear_mon();
        @(negedge CLK_I);
        drive(1'b1, 32'h3F0, 8'h77);
        @(negedge CLK_I);
        STB_I = 1'b0;
        repeat (2) @(negedge CLK_I);
        check("t5_we_active", sram_we_n, 1'b0);
        #2 RST_I = 1'b0;
        #1;
        check("t5_async_strobes", {sram_we_n, sram_ce_n, sram_dq_oe, ACK_O}, 4'b1100);
        @(negedge CLK_I);
        RST_I = 1'b1;
        repeat (10) @(negedge CLK_I);
        check("t5_no_ack", ack_cyc.size(), 0);
        check("t5_idle", sram_ce_n, 1'b1);

        // CYC_I dropped during the first of two queued reads
        clear_mon();
        @(negedge CLK_I);
        drive(1'b0, 32'h100, 8'h00);
        @(negedge CLK_I);
        drive(1'b0, 32'h101, 8'h00);
        @(negedge CLK_I);
        STB_I = 1'b0;
        @(negedge CLK_I);
        CYC_I = 1'b0;
        repeat (WC + 2) @(negedge CLK_I);
        check("t6_idle", sram_ce_n, 1'b1);
        repeat (2) @(negedge CLK_I);
        CYC_I = 1'b1;
        repeat (10) @(negedge CLK_I);
        check("t6_no_ack", ack_cyc.size(), 0);
        check("t6_fifo_empty", sram_ce_n, 1'b1);

        // Randomized bursts against the transaction model
        for (int b = 0; b < 20; b++) begin
            int n;
            clear_mon();
            burst.delete();
            n = $urandom_range(1, FD);
            for (int i = 0; i < n; i++) begin
                logic [31:0] a;
                a = ($urandom() & 32'hFFF8_0000) | 32'($urandom_range(0, 767));
                add_req(1'($urandom_range(0, 1)), a, 8'($urandom()));
            end
            run_burst("rnd");
            check("rnd_stall_seen", stall_seen, 1'b0);
        end
        for (int i = 0; i < 768; i++) begin
            if (sram[i] !== ref_mem[i]) check("rnd_sram_contents", sram[i], ref_mem[i]);
        end
        check("protocol_overlap", proto_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
